// File: rtl/wb_regstate_pkg.sv
// Shared pipeline types: writeback bundle layout and GPR addressing constants.
// Imported by the MEM/WB register and the architectural-state sink.
package cpu_pkg;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned DATA_W = 32;
  localparam logic [REG_AW-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic [REG_AW-1:0] wd;
    logic [DATA_W-1:0] wdata;
    logic              wreg;
    logic              whilo;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic              LLbit_we;
    logic              LLbit_value;
  } wb_bundle_t;

  // A GPR write only lands when enabled and not aimed at $0.
  function automatic logic gpr_wr_en(input logic wreg, input logic [REG_AW-1:0] wd);
    return wreg && (wd != ZERO_REG);
  endfunction

  function automatic logic gpr_wr_hit(input logic wreg, input logic [REG_AW-1:0] wd,
                                      input logic [REG_AW-1:0] raddr);
    return gpr_wr_en(wreg, wd) && (wd == raddr);
  endfunction

endpackage

// File: rtl/wb_regstate_regfile_2r1w.sv
// GPR array: two combinational read ports, one write port, $0 hardwired to zero.
// Optional same-cycle write-to-read bypass under WB_BYPASS_EN.
module regfile_2r1w
  import cpu_pkg::*;
#(
  parameter int unsigned NREGS = 32,
  parameter int unsigned DW    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DW-1:0]     wdata,
  input  logic              re1,
  input  logic [REG_AW-1:0] raddr1,
  input  logic              re2,
  input  logic [REG_AW-1:0] raddr2,
  output logic [DW-1:0]     rdata1,
  output logic [DW-1:0]     rdata2
);

  logic [DW-1:0] mem [NREGS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        mem[i[REG_AW-1:0]] <= '0;
      end
    end else if (gpr_wr_en(we, waddr)) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata1 = '0;
    if (re1 && (raddr1 != ZERO_REG)) begin
`ifdef WB_BYPASS_EN
      if (gpr_wr_hit(we, waddr, raddr1)) rdata1 = wdata;
      else                               rdata1 = mem[raddr1];
`else
      rdata1 = mem[raddr1];
`endif
    end
  end

  always_comb begin
    rdata2 = '0;
    if (re2 && (raddr2 != ZERO_REG)) begin
`ifdef WB_BYPASS_EN
      if (gpr_wr_hit(we, waddr, raddr2)) rdata2 = wdata;
      else                               rdata2 = mem[raddr2];
`else
      rdata2 = mem[raddr2];
`endif
    end
  end

endmodule

// File: rtl/wb_regstate.sv
// Architectural-state sink: GPR file, HI/LO pair and LLbit fed by the writeback bundle.
// Define WB_BYPASS_EN to make same-cycle writeback data visible on every read output.
module wb_regstate
  import cpu_pkg::*;
#(
  parameter int unsigned NREGS = 32,
  parameter int unsigned DW    = DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_wreg,
  input  logic [REG_AW-1:0] wb_wd,
  input  logic [DW-1:0]     wb_wdata,
  input  logic              wb_whilo,
  input  logic [DW-1:0]     wb_hi,
  input  logic [DW-1:0]     wb_lo,
  input  logic              wb_LLbit_we,
  input  logic              wb_LLbit_value,
  input  logic              flush,
  input  logic              re1,
  input  logic [REG_AW-1:0] raddr1,
  input  logic              re2,
  input  logic [REG_AW-1:0] raddr2,
  output logic [DW-1:0]     rdata1,
  output logic [DW-1:0]     rdata2,
  output logic [DW-1:0]     hi_o,
  output logic [DW-1:0]     lo_o,
  output logic              LLbit_o
);

  wb_bundle_t wb;
  logic [DW-1:0] hi_q, lo_q;
  logic          llbit_q;

  assign wb = '{wd:          wb_wd,
                wdata:       wb_wdata,
                wreg:        wb_wreg,
                whilo:       wb_whilo,
                hi:          wb_hi,
                lo:          wb_lo,
                LLbit_we:    wb_LLbit_we,
                LLbit_value: wb_LLbit_value};

  regfile_2r1w #(
    .NREGS (NREGS),
    .DW    (DW)
  ) u_gpr (
    .clk    (clk),
    .rst    (rst),
    .we     (wb.wreg),
    .waddr  (wb.wd),
    .wdata  (wb.wdata),
    .re1    (re1),
    .raddr1 (raddr1),
    .re2    (re2),
    .raddr2 (raddr2),
    .rdata1 (rdata1),
    .rdata2 (rdata2)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (wb.whilo) begin
      hi_q <= wb.hi;
      lo_q <= wb.lo;
    end
  end

  // flush outranks a pending LL so an exception between LL and SC kills the reservation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             llbit_q <= 1'b0;
    else if (flush)       llbit_q <= 1'b0;
    else if (wb.LLbit_we) llbit_q <= wb.LLbit_value;
  end

`ifdef WB_BYPASS_EN
  assign hi_o = wb.whilo ? wb.hi : hi_q;
  assign lo_o = wb.whilo ? wb.lo : lo_q;

  always_comb begin
    LLbit_o = llbit_q;
    if (flush)            LLbit_o = 1'b0;
    else if (wb.LLbit_we) LLbit_o = wb.LLbit_value;
  end
`else
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;
  assign LLbit_o = llbit_q;
`endif

endmodule

// File: tb/tb_wb_regstate.sv
// Directed scoreboard bench for wb_regstate; honours WB_BYPASS_EN when defined.
module tb_wb_regstate;

  localparam int unsigned DW = 32;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam int SEL_RD1 = 0;
  localparam int SEL_RD2 = 1;
  localparam int SEL_HI  = 2;
  localparam int SEL_LO  = 3;
  localparam int SEL_LL  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wb_wreg, wb_whilo, wb_LLbit_we, wb_LLbit_value, flush;
  logic [4:0]    wb_wd, raddr1, raddr2;
  logic [DW-1:0] wb_wdata, wb_hi, wb_lo;
  logic          re1, re2;
  logic [DW-1:0] rdata1, rdata2, hi_o, lo_o;
  logic          LLbit_o;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } sb_item_t;

  sb_item_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  wb_regstate #(.NREGS(32), .DW(DW)) dut (
    .clk            (clk),
    .rst            (rst),
    .wb_wreg        (wb_wreg),
    .wb_wd          (wb_wd),
    .wb_wdata       (wb_wdata),
    .wb_whilo       (wb_whilo),
    .wb_hi          (wb_hi),
    .wb_lo          (wb_lo),
    .wb_LLbit_we    (wb_LLbit_we),
    .wb_LLbit_value (wb_LLbit_value),
    .flush          (flush),
    .re1            (re1),
    .raddr1         (raddr1),
    .re2            (re2),
    .raddr2         (raddr2),
    .rdata1         (rdata1),
    .rdata2         (rdata2),
    .hi_o           (hi_o),
    .lo_o           (lo_o),
    .LLbit_o        (LLbit_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      SEL_RD1: return rdata1;
      SEL_RD2: return rdata2;
      SEL_HI:  return hi_o;
      SEL_LO:  return lo_o;
      default: return {31'd0, LLbit_o};
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [31:0] exp);
    sb_item_t it;
    it.tag = tag;
    it.sel = sel;
    it.exp = exp;
    sb.push_back(it);
  endtask

  // Settle combinational outputs, then drain every pending expectation.
  task automatic check_all();
    sb_item_t it;
    logic [31:0] obs;
    #2;
    while (sb.size() > 0) begin
      it  = sb.pop_front();
      obs = observe(it.sel);
      n_cmp++;
      assert (obs === it.exp) else begin
        n_bad++;
        $error("FAIL %s observed=%h expected=%h", it.tag, obs, it.exp);
      end
    end
  endtask

  task automatic idle_bundle();
    wb_wreg = 1'b0; wb_wd = 5'd0; wb_wdata = '0;
    wb_whilo = 1'b0; wb_hi = '0; wb_lo = '0;
    wb_LLbit_we = 1'b0; wb_LLbit_value = 1'b0; flush = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    idle_bundle();
    re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd5;
    #3;
    push("rst_rd1", SEL_RD1, 32'h0);
    push("rst_hi",  SEL_HI,  32'h0);
    push("rst_lo",  SEL_LO,  32'h0);
    push("rst_ll",  SEL_LL,  32'h0);
    check_all();
    next_cycle();
    rst = 1'b1;

    // Load r5, HI/LO and LLbit so the reset check below sees them cleared.
    next_cycle();
    wb_wreg = 1'b1; wb_wd = 5'd5; wb_wdata = 32'hDEADBEEF;
    wb_whilo = 1'b1; wb_hi = 32'h11; wb_lo = 32'h22;
    wb_LLbit_we = 1'b1; wb_LLbit_value = 1'b1;
    next_cycle();
    idle_bundle();
    push("pre_rst_r5", SEL_RD1, 32'hDEADBEEF);
    push("pre_rst_hi", SEL_HI,  32'h11);
    push("pre_rst_lo", SEL_LO,  32'h22);
    push("pre_rst_ll", SEL_LL,  32'h1);
    check_all();

    // Mid-cycle async reset, with a write bundle presented while held.
    rst = 1'b0;
    push("async_rst_r5", SEL_RD1, 32'h0);
    push("async_rst_hi", SEL_HI,  32'h0);
    push("async_rst_lo", SEL_LO,  32'h0);
    push("async_rst_ll", SEL_LL,  32'h0);
    check_all();
    wb_wreg = 1'b1; wb_wd = 5'd6; wb_wdata = 32'hCAFEF00D;
    next_cycle();
    idle_bundle();
    rst = 1'b1;
    raddr1 = 5'd6;
    push("rst_mid_write_lost", SEL_RD1, 32'h0);
    check_all();

    // First edge after release accepts a write; r7 read on both ports.
    next_cycle();
    wb_wreg = 1'b1; wb_wd = 5'd7; wb_wdata = 32'h12345678;
    next_cycle();
    idle_bundle();
    raddr1 = 5'd7; raddr2 = 5'd7;
    push("r7_port1", SEL_RD1, 32'h12345678);
    push("r7_port2", SEL_RD2, 32'h12345678);
    check_all();

    // Disabled port returns zero regardless of address.
    re2 = 1'b0;
    push("re2_off", SEL_RD2, 32'h0);
    push("re1_on",  SEL_RD1, 32'h12345678);
    check_all();
    re2 = 1'b1;

    // Write to $0 is discarded.
    next_cycle();
    wb_wreg = 1'b1; wb_wd = 5'd0; wb_wdata = 32'hFFFFFFFF;
    raddr1 = 5'd0;
    push("r0_same_cycle", SEL_RD1, 32'h0);
    check_all();
    next_cycle();
    idle_bundle();
    push("r0_after", SEL_RD1, 32'h0);
    check_all();

    // Disabled write with live address/data must not disturb r7.
    next_cycle();
    wb_wreg = 1'b0; wb_wd = 5'd7; wb_wdata = 32'h0BADF00D;
    next_cycle();
    idle_bundle();
    raddr1 = 5'd7;
    push("wreg0_hold_r7", SEL_RD1, 32'h12345678);
    check_all();

    // Bypass: r9 old value 0x11111111, then same-cycle write of 0xA5A5A5A5.
    next_cycle();
    wb_wreg = 1'b1; wb_wd = 5'd9; wb_wdata = 32'h11111111;
    next_cycle();
    wb_wdata = 32'hA5A5A5A5;
    raddr1 = 5'd9; raddr2 = 5'd7;
    push("bypass_r9_same", SEL_RD1, BYP ? 32'hA5A5A5A5 : 32'h11111111);
    push("bypass_other",   SEL_RD2, 32'h12345678);
    check_all();
    next_cycle();
    idle_bundle();
    push("bypass_r9_next", SEL_RD1, 32'hA5A5A5A5);
    check_all();

    // HI/LO pair write, then hold with new data but no enable.
    next_cycle();
    wb_whilo = 1'b1; wb_hi = 32'h1; wb_lo = 32'h2;
    push("hi_same", SEL_HI, BYP ? 32'h1 : 32'h0);
    push("lo_same", SEL_LO, BYP ? 32'h2 : 32'h0);
    check_all();
    next_cycle();
    wb_whilo = 1'b0; wb_hi = 32'h99; wb_lo = 32'h88;
    push("hi_written", SEL_HI, 32'h1);
    push("lo_written", SEL_LO, 32'h2);
    check_all();
    next_cycle();
    idle_bundle();
    push("hi_hold", SEL_HI, 32'h1);
    push("lo_hold", SEL_LO, 32'h2);
    check_all();

    // LLbit set, hold, then flush beating a concurrent set.
    next_cycle();
    wb_LLbit_we = 1'b1; wb_LLbit_value = 1'b1;
    push("ll_set_same", SEL_LL, BYP ? 32'h1 : 32'h0);
    check_all();
    next_cycle();
    idle_bundle();
    push("ll_set", SEL_LL, 32'h1);
    check_all();
    next_cycle();
    push("ll_hold", SEL_LL, 32'h1);
    check_all();
    flush = 1'b1; wb_LLbit_we = 1'b1; wb_LLbit_value = 1'b1;
    push("ll_flush_same", SEL_LL, BYP ? 32'h0 : 32'h1);
    check_all();
    next_cycle();
    idle_bundle();
    push("ll_flush_prio", SEL_LL, 32'h0);
    check_all();

    // Set again, then clear via wb_LLbit_value=0.
    next_cycle();
    wb_LLbit_we = 1'b1; wb_LLbit_value = 1'b1;
    next_cycle();
    wb_LLbit_value = 1'b0;
    push("ll_reset_same", SEL_LL, BYP ? 32'h0 : 32'h1);
    check_all();
    next_cycle();
    idle_bundle();
    push("ll_cleared", SEL_LL, 32'h0);
    check_all();

    // Both ports on the same register after a further write.
    next_cycle();
    wb_wreg = 1'b1; wb_wd = 5'd31; wb_wdata = 32'h5A5A0F0F;
    next_cycle();
    idle_bundle();
    raddr1 = 5'd31; raddr2 = 5'd31;
    push("r31_port1", SEL_RD1, 32'h5A5A0F0F);
    push("r31_port2", SEL_RD2, 32'h5A5A0F0F);
    check_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
